alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 32-bit ALU between two requesters (req0: main datapath, req1: branch/address unit).
// - Valid/ready request channel per requester, single tagged response channel, one-entry result register.
// - Round-robin grant; 1-cycle latency; 1 op/cycle sustained when the response side is always ready.
// PARAMETERS
// - DATA_W  32  operand/result width
// - CTRL_W  3   ALU control width; encoding below is fixed
// PORTS
// - clk         in   1       single clock, rising edge
// - reset       in   1       asynchronous, active-high reset
// - req0_valid  in   1       requester 0 has an op
// - req0_ready  out  1       requester 0 op accepted this cycle (valid&&ready)
// - req0_srca   in   DATA_W  operand A
// - req0_srcb   in   DATA_W  operand B
// - req0_ctrl   in   CTRL_W  ALU control
// - req1_valid / req1_ready / req1_srca / req1_srcb / req1_ctrl   same as req0, requester 1
// - rsp_valid   out  1       result register holds a result
// - rsp_ready   in   1       consumer takes result this cycle
// - rsp_id      out  1       requester that issued the result (0/1)
// - rsp_result  out  DATA_W  ALU result
// - rsp_zero    out  1       1 iff rsp_result == 0
// BEHAVIOUR
// - Reset (async): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rr_ptr=0 (req0 preferred first).
// - Reset mid-operation: held result is discarded; no response for in-flight ops; requesters re-present.
// - Ctrl: 000 A+B; 001 A-B; 111 A&B; 011 A|B; 101 (A<B unsigned) ? 1 : 0; any other code -> A+B.
// - Add/sub wrap modulo 2^DATA_W; SLTU result zero-extended; rsp_zero computed from the same registered result.
// - slot_free = !rsp_valid || rsp_ready (pass-through: drain and refill in the same cycle).
// - Grant (comb.): only one valid -> that one; both valid -> rr_ptr; neither -> none.
// - reqN_ready = slot_free && grant==N; never both high; ready may be high with valid low only if unused.
// - On accept of N: next edge rsp_valid=1, rsp_id=N, rsp_result/zero from N's operands; rr_ptr = ~N.
// - No accept and rsp_ready: rsp_valid -> 0, data fields hold last value.
// - rsp_valid && !rsp_ready: rsp_id/result/zero stable; no req ready asserted.
// - Requesters hold srca/srcb/ctrl stable while valid && !ready; valid is not withdrawn before accept.
// - Fairness: with both valid continuously, grants alternate 0,1,0,1...; each waits at most one accept.
// - States: EMPTY (rsp_valid=0) -> FULL on accept; FULL -> FULL on accept&&rsp_ready;
//   FULL -> EMPTY on rsp_ready&&!accept; FULL stays on !rsp_ready.
// CONFIGURATION
// - ALU_ARB_FIXED_PRIO_EN defined: req0 always wins when both valid; rr_ptr unused (held 0).
// - Not defined: round-robin as above (default build).
// TESTING
// - Reset, req0 add 5+7, rsp_ready=1 -> cycle+1: rsp_valid=1, id=0, result=12, zero=0.
// - req1 sub 9-9 -> result=0, zero=1, id=1; req1 sltu 3,0xFFFFFFFF -> result=1.
// - Both valid 4 cycles, rsp_ready=1 -> ids 0,1,0,1; with FIXED_PRIO_EN -> 0,0,0,0.
// - rsp_ready=0 for 3 cycles while FULL -> rsp fields stable, req0/req1_ready=0; release -> next op accepted same cycle.
// - add 0xFFFFFFFF+1 -> result=0, zero=1; ctrl=010 with 2,3 -> result=5 (default add).
// - Assert reset while FULL and both valid -> rsp_valid drops immediately; after release first grant goes to req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one 32-bit ALU shared by two valid/ready requesters.
// Grants are combinational (round-robin between simultaneous requests), and
// the result lands in a single tagged response register one cycle later. That
// register drains and refills in the same cycle whenever rsp_ready is high.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN. When it is defined, req0 always
// wins a tie and the round-robin pointer stays at 0.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_srca,
  input  logic [DATA_W-1:0] req0_srcb,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_srca,
  input  logic [DATA_W-1:0] req1_srcb,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  localparam logic [CTRL_W-1:0] CTRL_ADD  = CTRL_W'(3'b000);
  localparam logic [CTRL_W-1:0] CTRL_SUB  = CTRL_W'(3'b001);
  localparam logic [CTRL_W-1:0] CTRL_OR   = CTRL_W'(3'b011);
  localparam logic [CTRL_W-1:0] CTRL_SLTU = CTRL_W'(3'b101);
  localparam logic [CTRL_W-1:0] CTRL_AND  = CTRL_W'(3'b111);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              rr_ptr;
  logic              rr_ptr_next;
  logic              grant;
  logic              grant_valid;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CTRL_W-1:0] op_ctrl;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] result;
  logic              id;
  logic              zero;

  // Pick a winner. A lone requester always wins; on a tie, rr_ptr decides.
  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr_ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Route the winner's operands to the ALU and evaluate it.
  // Unlisted control codes behave as add.
  always_comb begin
    op_a    = grant ? req1_srca : req0_srca;
    op_b    = grant ? req1_srcb : req0_srcb;
    op_ctrl = grant ? req1_ctrl : req0_ctrl;
    case (op_ctrl)
      CTRL_ADD:  alu_out = op_a + op_b;
      CTRL_SUB:  alu_out = op_a - op_b;
      CTRL_AND:  alu_out = op_a & op_b;
      CTRL_OR:   alu_out = op_a | op_b;
      CTRL_SLTU: alu_out = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      default:   alu_out = op_a + op_b;
    endcase
  end

  // Slot occupancy, handshakes, and next state / next pointer.
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    slot_free   = (state == EMPTY) || rsp_ready;
    accept      = slot_free && grant_valid;
    req0_ready  = accept && !grant;
    req1_ready  = accept && grant;
    if (accept) begin
      state_next = FULL;
    end else if (rsp_ready) begin
      state_next = EMPTY;
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_next = 1'b0;
`else
    if (accept) begin
      rr_ptr_next = ~grant;
    end
`endif
  end

  // Hold the occupancy state and the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Capture the result and its tag on accept. When the slot drains with no
  // new accept, the data fields keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      id     <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      result <= alu_out;
      id     <= grant;
      zero   <= (alu_out == '0);
    end
  end

  assign rsp_valid  = (state == FULL);
  assign rsp_id     = id;
  assign rsp_result = result;
  assign rsp_zero   = zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. Directed scenarios and a randomized run are
// checked against a transaction-level model held in the bench: a tie goes to
// the requester that did not win last, and the response slot is either
// holding a result or empty.
module tb_alu_share_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state.
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_result;
  bit          m_zero;
  bit          m_last;   // requester that won most recently
  bit          m_win;
  bit          m_acc;
  bit          exp_r0, exp_r1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b111:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = 1'b0;
    m_result = 32'd0;
    m_zero   = 1'b0;
    m_last   = 1'b1;   // so that req0 is preferred first
  endtask

  // Predict who may hand over an op this cycle, given the inputs currently driven.
  task automatic model_comb();
    bit slot;
    slot = !m_valid || rsp_ready;
    if (req0_valid && req1_valid) m_win = FIXED ? 1'b0 : !m_last;
    else                          m_win = req1_valid;
    m_acc  = slot && (req0_valid || req1_valid);
    exp_r0 = m_acc && !m_win;
    exp_r1 = m_acc && m_win;
  endtask

  // Apply the clock edge to the model.
  task automatic model_edge();
    if (m_acc) begin
      m_result = m_win ? alu_ref(req1_srca, req1_srcb, req1_ctrl)
                       : alu_ref(req0_srca, req0_srcb, req0_ctrl);
      m_zero   = (m_result == 32'd0);
      m_id     = m_win;
      m_valid  = 1'b1;
      m_last   = m_win;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
    req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rsp_ready = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0b id=%0b res=%h z=%0b, want all zero",
               rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    reset = 1'b0;
    $display("reset: v=%0b id=%0b res=%h z=%0b", rsp_valid, rsp_id, rsp_result, rsp_zero);
  endtask

  task automatic test_single_op(input string name, input bit n, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] c,
                                input logic [31:0] want_res, input bit want_zero);
    idle_inputs();
    rsp_ready = 1'b1;
    if (n) begin req1_valid = 1'b1; req1_srca = a; req1_srcb = b; req1_ctrl = c; end
    else   begin req0_valid = 1'b1; req0_srca = a; req0_srcb = b; req0_ctrl = c; end
    #1;
    model_comb();
    n_cmp++;
    if ({req1_ready, req0_ready} !== {n, !n}) begin
      n_bad++;
      $display("FAIL %s_ready: got %b want %b", name, {req1_ready, req0_ready}, {n, !n});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, n, want_res, want_zero}) begin
      n_bad++;
      $display("FAIL %s: got v=%0b id=%0b res=%h z=%0b, want v=1 id=%0b res=%h z=%0b",
               name, rsp_valid, rsp_id, rsp_result, rsp_zero, n, want_res, want_zero);
    end
    $display("%s: id=%0b a=%h b=%h ctrl=%b -> res=%h z=%0b", name, n, a, b, c,
             rsp_result, rsp_zero);
  endtask

  task automatic test_fairness();
    bit want_id;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = $urandom; req0_srcb = $urandom; req0_ctrl = 3'($urandom);
    req1_valid = 1'b1; req1_srca = $urandom; req1_srcb = $urandom; req1_ctrl = 3'($urandom);
    for (int i = 0; i < 4; i++) begin
      #1;
      model_comb();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      want_id = FIXED ? 1'b0 : i[0];
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, want_id, m_result, m_zero}) begin
        n_bad++;
        $display("FAIL fairness_%0d: got v=%0b id=%0b res=%h, want v=1 id=%0b res=%h",
                 i, rsp_valid, rsp_id, rsp_result, want_id, m_result);
      end
      $display("fairness %0d: id=%0b res=%h", i, rsp_id, rsp_result);
      if (m_win) begin req1_srca = $urandom; req1_srcb = $urandom; req1_ctrl = 3'($urandom); end
      else       begin req0_srca = $urandom; req0_srcb = $urandom; req0_ctrl = 3'($urandom); end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd100; req0_srcb = 32'd23; req0_ctrl = 3'b000;
    #1; model_comb();
    @(posedge clk); model_edge();
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_srca = 32'd40; req0_srcb = 32'd2; req0_ctrl = 3'b001;
    req1_valid = 1'b1; req1_srca = 32'h0ff0; req1_srcb = 32'h00ff; req1_ctrl = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1; model_comb();
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_bad++;
        $display("FAIL stall_ready_%0d: got %b want 00", i, {req1_ready, req0_ready});
      end
      @(posedge clk); model_edge();
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 32'd123, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got v=%0b id=%0b res=%h z=%0b, want v=1 id=0 res=7b z=0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
      $display("stall %0d: v=%0b id=%0b res=%h", i, rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    #1; model_comb();
    n_cmp++;
    if ({req1_ready, req0_ready} !== (FIXED ? 2'b01 : 2'b10)) begin
      n_bad++;
      $display("FAIL release_ready: got %b want %b", {req1_ready, req0_ready},
               FIXED ? 2'b01 : 2'b10);
    end
    @(posedge clk); model_edge();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, m_id, m_result, m_zero}) begin
      n_bad++;
      $display("FAIL release_rsp: got v=%0b id=%0b res=%h, want v=1 id=%0b res=%h",
               rsp_valid, rsp_id, rsp_result, m_id, m_result);
    end
    $display("release: id=%0b res=%h", rsp_id, rsp_result);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd8; req0_srcb = 32'd9; req0_ctrl = 3'b000;
    #1; model_comb();
    @(posedge clk); model_edge();
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_srca = 32'd1; req1_srcb = 32'd1; req1_ctrl = 3'b000;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_valid: got %0b want 0", rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1; model_comb();
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_grant: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); model_edge();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 32'd17, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_rsp: got v=%0b id=%0b res=%h, want v=1 id=0 res=11",
               rsp_valid, rsp_id, rsp_result);
    end
    $display("reset_mid: id=%0b res=%h", rsp_id, rsp_result);
    idle_inputs();
  endtask

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // A requester keeps an unaccepted op on its inputs unchanged.
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_srca = rand_operand(); req0_srcb = rand_operand();
        req0_ctrl = 3'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_srca = rand_operand(); req1_srcb = rand_operand();
        req1_ctrl = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1; model_comb();
      n_cmp++;
      if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin
        n_bad++;
        $display("FAIL rand_ready_%0d: got %b want %b", i, {req1_ready, req0_ready},
                 {exp_r1, exp_r0});
      end
      @(posedge clk); model_edge();
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {m_valid, m_id, m_result, m_zero}) begin
        n_bad++;
        $display("FAIL rand_rsp_%0d: got v=%0b id=%0b res=%h z=%0b, want v=%0b id=%0b res=%h z=%0b",
                 i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_valid, m_id, m_result, m_zero);
      end
      $display("rand %0d: acc=%0b win=%0b v=%0b id=%0b res=%h", i, m_acc, m_win,
               rsp_valid, rsp_id, rsp_result);
      if (m_acc) begin
        if (m_win) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_op("add_5_7",     1'b0, 32'd5,        32'd7,        3'b000, 32'd12,     1'b0);
    test_single_op("sub_9_9",     1'b1, 32'd9,        32'd9,        3'b001, 32'd0,      1'b1);
    test_single_op("sltu_3_max",  1'b1, 32'd3,        32'hFFFFFFFF, 3'b101, 32'd1,      1'b0);
    test_single_op("sltu_max_3",  1'b0, 32'hFFFFFFFF, 32'd3,        3'b101, 32'd0,      1'b1);
    test_single_op("add_wrap",    1'b0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,      1'b1);
    test_single_op("dflt_010",    1'b1, 32'd2,        32'd3,        3'b010, 32'd5,      1'b0);
    test_single_op("and",         1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b111, 32'h0000F000, 1'b0);
    test_single_op("or",          1'b0, 32'h0000F0F0, 32'h00000F00, 3'b011, 32'h0000FFF0, 1'b0);
    test_single_op("sub_wrap",    1'b0, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 1'b0);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
